// File: rtl/trafficlight_param.sv
// Two-road highway/country signal controller with all-red clearance, capped country green, latched pedestrian request and emergency override.
// Latency: Moore outputs decoded from the state register; a lamp changes on the same edge that takes the transition.
// Backpressure: none; sensor, button and override inputs are sampled every cycle and the lamps are always driven.
module trafficlight_param #(
    parameter int MIN_HW_GREEN = 8,
    parameter int Y_CYCLES     = 3,
    parameter int AR_CYCLES    = 2,
    parameter int MIN_CR_GREEN = 4,
    parameter int MAX_CR_GREEN = 10,
    // Wide enough for the longest phase count; MIN_CR_GREEN never exceeds MAX_CR_GREEN.
    parameter int TIMER_W = $clog2(
        (((MIN_HW_GREEN > Y_CYCLES) ? MIN_HW_GREEN : Y_CYCLES) >
         ((AR_CYCLES > MAX_CR_GREEN) ? AR_CYCLES : MAX_CR_GREEN))
        ? ((MIN_HW_GREEN > Y_CYCLES) ? MIN_HW_GREEN : Y_CYCLES) + 1
        : ((AR_CYCLES > MAX_CR_GREEN) ? AR_CYCLES : MAX_CR_GREEN) + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       x,
    input  logic       ped_req,
    input  logic       emg,
    output logic [1:0] highway,
    output logic [1:0] country,
    output logic       ped_walk,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_HW_GREEN  = 3'd0,
        S_HW_YELLOW = 3'd1,
        S_AR1       = 3'd2,
        S_CR_GREEN  = 3'd3,
        S_CR_YELLOW = 3'd4,
        S_AR2       = 3'd5
    } state_t;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

    // Terminal timer values: a phase of N cycles ends when the timer reads N-1.
    localparam logic [TIMER_W-1:0] T_HW_MIN = TIMER_W'(MIN_HW_GREEN - 1);
    localparam logic [TIMER_W-1:0] T_Y      = TIMER_W'(Y_CYCLES - 1);
    localparam logic [TIMER_W-1:0] T_AR     = TIMER_W'(AR_CYCLES - 1);
    localparam logic [TIMER_W-1:0] T_CR_MIN = TIMER_W'(MIN_CR_GREEN - 1);
    localparam logic [TIMER_W-1:0] T_CR_MAX = TIMER_W'(MAX_CR_GREEN - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TIMER_W-1:0]   r_timer;
    logic                 r_ped_pending;
    logic                 w_req;
    logic                 w_state_chg;
    logic                 w_enter_cr;

    assign w_req       = x | r_ped_pending;
    assign w_state_chg = (w_state_nxt != r_state);
    assign w_enter_cr  = (w_state_nxt == S_CR_GREEN) && (r_state != S_CR_GREEN);

    // State register; reset lands directly in highway green, skipping yellow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_HW_GREEN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Phase timer: restarts at every transition, otherwise counts up and saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
        end else if (w_state_chg) begin
            r_timer <= '0;
        end else if (r_timer != '1) begin
            r_timer <= r_timer + TIMER_W'(1);
        end
    end

    // Pedestrian latch: served by the next country green; entering it wins over a new press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ped_pending <= 1'b0;
        end else if (w_enter_cr) begin
            r_ped_pending <= 1'b0;
        end else if (ped_req && (r_state != S_CR_GREEN)) begin
            r_ped_pending <= 1'b1;
        end
    end

    // Next-state logic; yellow and the post-country all-red always run to completion.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HW_GREEN: begin
                if (w_req && !emg && (r_timer >= T_HW_MIN)) begin
                    w_state_nxt = S_HW_YELLOW;
                end
            end
            S_HW_YELLOW: begin
                if (r_timer == T_Y) begin
                    w_state_nxt = S_AR1;
                end
            end
            S_AR1: begin
                // An emergency arriving during clearance skips the country green.
                if (r_timer == T_AR) begin
                    w_state_nxt = emg ? S_AR2 : S_CR_GREEN;
                end
            end
            S_CR_GREEN: begin
                if (emg || (r_timer == T_CR_MAX) || (!x && (r_timer >= T_CR_MIN))) begin
                    w_state_nxt = S_CR_YELLOW;
                end
            end
            S_CR_YELLOW: begin
                if (r_timer == T_Y) begin
                    w_state_nxt = S_AR2;
                end
            end
            S_AR2: begin
                if (r_timer == T_AR) begin
                    w_state_nxt = S_HW_GREEN;
                end
            end
            default: begin
                // Codes 6 and 7 recover to highway green on the next edge.
                w_state_nxt = S_HW_GREEN;
            end
        endcase
    end

    // Lamp decode from the state register only; illegal codes show all red.
    always_comb begin
        highway  = LAMP_RED;
        country  = LAMP_RED;
        ped_walk = 1'b0;
        case (r_state)
            S_HW_GREEN:  highway = LAMP_GREEN;
            S_HW_YELLOW: highway = LAMP_YELLOW;
            S_CR_GREEN: begin
                country  = LAMP_GREEN;
                ped_walk = 1'b1;
            end
            S_CR_YELLOW: country = LAMP_YELLOW;
            default: begin
                highway = LAMP_RED;
                country = LAMP_RED;
            end
        endcase
    end

    assign state_o = r_state;

endmodule

// File: tb/tb_trafficlight_param.sv
// Directed bench for trafficlight_param: phase lengths, lamp decode, pedestrian and emergency paths.
// Inputs are driven and outputs sampled on the falling clock edge, away from the active edge.
// Every wait on the design is bounded by a cycle budget.
module tb_trafficlight_param;

    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] GRN = 2'b10;

    logic       clk;
    logic       rst;
    logic       x;
    logic       ped_req;
    logic       emg;
    logic [1:0] highway;
    logic [1:0] country;
    logic       ped_walk;
    logic [2:0] state_o;

    int n_tests = 0;
    int n_fail  = 0;

    trafficlight_param dut (
        .clk      (clk),
        .rst      (rst),
        .x        (x),
        .ped_req  (ped_req),
        .emg      (emg),
        .highway  (highway),
        .country  (country),
        .ped_walk (ped_walk),
        .state_o  (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observe one phase from its first falling edge; checks entry state, length and lamps throughout.
    task automatic phase(input string tag, input logic [2:0] s, input int len,
                         input logic [1:0] hw, input logic [1:0] cr, input logic walk);
        int n;
        bit bad;
        n   = 0;
        bad = 1'b0;
        chk({tag, "_entry"}, 32'(state_o), 32'(s));
        while (state_o == s && n < 64) begin
            if (highway !== hw || country !== cr || ped_walk !== walk) bad = 1'b1;
            n++;
            @(negedge clk);
        end
        chk({tag, "_len"}, n, len);
        chk({tag, "_lamps"}, 32'(bad), 0);
    endtask

    // Check that the design sits in highway green for a number of cycles.
    task automatic hold_s0(input string tag, input int cycles);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (state_o !== 3'd0 || highway !== GRN || country !== RED) bad = 1'b1;
            @(negedge clk);
        end
        chk(tag, 32'(bad), 0);
    endtask

    // Pulse reset for two cycles and release on a falling edge.
    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int n;
        rst     = 1'b0;
        x       = 1'b0;
        ped_req = 1'b0;
        emg     = 1'b0;

        // 1: reset values, then idle highway green with no car.
        #20;
        chk("rst_hw",   32'(highway),  32'(GRN));
        chk("rst_cr",   32'(country),  32'(RED));
        chk("rst_walk", 32'(ped_walk), 0);
        chk("rst_st",   32'(state_o),  0);
        rst = 1'b1;
        hold_s0("idle_hold", 10);

        // 2: car present throughout; country green capped at its maximum.
        do_reset();
        x = 1'b1;
        phase("t2_s0",  3'd0, 8,  GRN, RED, 1'b0);
        phase("t2_s1",  3'd1, 3,  YEL, RED, 1'b0);
        phase("t2_ar1", 3'd2, 2,  RED, RED, 1'b0);
        phase("t2_s3",  3'd3, 10, RED, GRN, 1'b1);
        phase("t2_s4",  3'd4, 3,  RED, YEL, 1'b0);
        phase("t2_ar2", 3'd5, 2,  RED, RED, 1'b0);
        phase("t2_s0b", 3'd0, 8,  GRN, RED, 1'b0);
        chk("t2_repeat", 32'(state_o), 1);
        x = 1'b0;

        // 3: one-cycle car pulse late in highway green; minimum country green.
        do_reset();
        for (int i = 0; i < 20; i++) @(negedge clk);
        chk("t3_pre", 32'(state_o), 0);
        x = 1'b1;
        @(negedge clk);
        x = 1'b0;
        phase("t3_s1",  3'd1, 3, YEL, RED, 1'b0);
        phase("t3_ar1", 3'd2, 2, RED, RED, 1'b0);
        phase("t3_s3",  3'd3, 4, RED, GRN, 1'b1);
        phase("t3_s4",  3'd4, 3, RED, YEL, 1'b0);
        phase("t3_ar2", 3'd5, 2, RED, RED, 1'b0);
        hold_s0("t3_hold", 30);

        // 4: pedestrian pulse with no car; walk aligned with country green, latch cleared after.
        do_reset();
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        phase("t4_s0",  3'd0, 7, GRN, RED, 1'b0);
        phase("t4_s1",  3'd1, 3, YEL, RED, 1'b0);
        phase("t4_ar1", 3'd2, 2, RED, RED, 1'b0);
        phase("t4_s3",  3'd3, 4, RED, GRN, 1'b1);
        phase("t4_s4",  3'd4, 3, RED, YEL, 1'b0);
        phase("t4_ar2", 3'd5, 2, RED, RED, 1'b0);
        hold_s0("t4_pend_clr", 30);

        // 5: emergency at country green t=1 cuts it short, then holds highway green.
        do_reset();
        x = 1'b1;
        phase("t5_s0",  3'd0, 8, GRN, RED, 1'b0);
        phase("t5_s1",  3'd1, 3, YEL, RED, 1'b0);
        phase("t5_ar1", 3'd2, 2, RED, RED, 1'b0);
        chk("t5_s3_t0", 32'(state_o), 3);
        @(negedge clk);
        chk("t5_s3_t1", 32'(state_o), 3);
        emg = 1'b1;
        @(negedge clk);
        chk("t5_cr_yel", 32'(country), 32'(YEL));
        phase("t5_s4",  3'd4, 3, RED, YEL, 1'b0);
        phase("t5_ar2", 3'd5, 2, RED, RED, 1'b0);
        hold_s0("t5_emg_hold", 20);
        emg = 1'b0;
        @(negedge clk);
        chk("t5_release", 32'(state_o), 1);
        x = 1'b0;

        // 6: emergency during highway yellow skips the country green entirely.
        do_reset();
        x = 1'b1;
        phase("t6_s0", 3'd0, 8, GRN, RED, 1'b0);
        emg = 1'b1;
        phase("t6_s1",  3'd1, 3, YEL, RED, 1'b0);
        phase("t6_ar1", 3'd2, 2, RED, RED, 1'b0);
        phase("t6_ar2", 3'd5, 2, RED, RED, 1'b0);
        hold_s0("t6_emg_hold", 10);
        emg = 1'b0;

        // 6b: asynchronous reset in the middle of country green.
        n = 0;
        while (state_o != 3'd3 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("t6_reach_s3", 32'(state_o), 3);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_arst_hw",   32'(highway),  32'(GRN));
        chk("t6_arst_cr",   32'(country),  32'(RED));
        chk("t6_arst_walk", 32'(ped_walk), 0);
        chk("t6_arst_st",   32'(state_o),  0);
        @(negedge clk);
        rst = 1'b1;
        x   = 1'b0;
        hold_s0("t6_post_rst", 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
